// File: rtl/cms_trace_packer.sv
// Trace record packer: captures one record per executed instruction, packs several
// records per AXI-Stream beat, buffers beats in a FIFO and marks packet ends with tlast.
module cms_trace_packer #(
  parameter int XLEN                                = 64,
  parameter int INSTR_WIDTH                         = 32,
  parameter int NUM_COUNTERS                        = 3,
  parameter int COUNTER_WIDTH                       = 7,
  parameter int RECORD_WIDTH                        = 128,
  parameter int AXI_DATA_WIDTH                      = 512,
  parameter int FIFO_DEPTH                          = 8,
  parameter int CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [INSTR_WIDTH-1:0]          instr,
  input  logic [XLEN-1:0]                 pc,
  input  logic                            pc_valid,
  input  logic [NUM_COUNTERS-1:0]         performance_events,
  input  logic                            en,
  input  logic [7:0]                      ctrl_addr,
  input  logic [63:0]                     ctrl_wdata,
  input  logic                            ctrl_write_enable,
  input  logic [31:0]                     tlast_interval,
  output logic                            M_AXIS_tvalid,
  input  logic                            M_AXIS_tready,
  output logic [AXI_DATA_WIDTH-1:0]       M_AXIS_tdata,
  output logic                            M_AXIS_tlast,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [31:0]                     drop_count,
  output logic                            overflow
);

  localparam int RPB = AXI_DATA_WIDTH / RECORD_WIDTH;
  localparam int SW  = (RPB > 1) ? $clog2(RPB) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  logic                      run;
  logic                      we_d;
  logic [SW-1:0]             slot;
  logic [31:0]               beat_cnt;
  logic [COUNTER_WIDTH-1:0]  cnt     [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0]  cnt_sat [NUM_COUNTERS];
  logic [RECORD_WIDTH-1:0]   record;
  logic [AXI_DATA_WIDTH-1:0] beat_buf, beat_next;

  logic [AXI_DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic                      mem_last [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [AW:0]               count;

  logic ctrl_stb, wr_run, do_flush, do_clear;
  logic active, capture, last_slot, beat_done, flush_push, push;
  logic push_tlast, full, pop, push_ok, drop;
  logic [31:0] tl_thresh;
  logic unused_wdata;

  assign unused_wdata = ^ctrl_wdata[63:1];

  // Edge-triggered mode acts only on the first cycle of a held strobe.
  assign ctrl_stb = ctrl_write_enable &
                    ((CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED != 0) ? ~we_d : 1'b1);
  assign wr_run   = ctrl_stb && (ctrl_addr == 8'h00);
  assign do_flush = ctrl_stb && (ctrl_addr == 8'h01);
  assign do_clear = ctrl_stb && (ctrl_addr == 8'h02);

  assign active     = en & run;
  assign capture    = active & pc_valid;
  assign last_slot  = (slot == SW'(RPB - 1));
  assign beat_done  = capture & last_slot;
  assign flush_push = do_flush & ((slot != '0) | capture);
  assign push       = beat_done | flush_push;

  // ">=" rather than "==" so a shrunk interval still closes the packet on the next push.
  assign tl_thresh  = (tlast_interval == 32'd0) ? 32'd0 : tlast_interval - 32'd1;
  assign push_tlast = flush_push | (beat_cnt >= tl_thresh);

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = (count != '0) & M_AXIS_tready;
  assign push_ok = push & (~full | pop);
  assign drop    = push & ~push_ok;

  always_comb begin
    for (int i = 0; i < NUM_COUNTERS; i++)
      cnt_sat[i] = (cnt[i] == '1) ? cnt[i] : cnt[i] + COUNTER_WIDTH'(performance_events[i]);
  end

  always_comb begin
    record = '0;
    record[INSTR_WIDTH-1:0]       = instr;
    record[INSTR_WIDTH +: XLEN]   = pc;
    for (int i = 0; i < NUM_COUNTERS; i++)
      record[INSTR_WIDTH + XLEN + i*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt_sat[i];
  end

  always_comb begin
    beat_next = beat_buf;
    for (int s = 0; s < RPB; s++)
      if (capture && (slot == SW'(s)))
        beat_next[s*RECORD_WIDTH +: RECORD_WIDTH] = record;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run        <= 1'b0;
      we_d       <= 1'b0;
      slot       <= '0;
      beat_cnt   <= '0;
      beat_buf   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < NUM_COUNTERS; i++) cnt[i] <= '0;
    end else begin
      we_d <= ctrl_write_enable;
      if (wr_run) run <= ctrl_wdata[0];

      if (active)
        for (int i = 0; i < NUM_COUNTERS; i++)
          cnt[i] <= capture ? '0 : cnt_sat[i];

      // Clearing the buffer after a push keeps unused slots of a flushed beat zero.
      if (push) begin
        beat_buf <= '0;
        slot     <= '0;
      end else if (capture) begin
        beat_buf <= beat_next;
        slot     <= slot + SW'(1);
      end

      if (push_ok) begin
        beat_cnt <= push_tlast ? 32'd0 : beat_cnt + 32'd1;
        wr_ptr   <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);

      if (do_clear) begin
        drop_count <= drop ? 32'd1 : 32'd0;
        overflow   <= drop;
      end else if (drop) begin
        if (drop_count != '1) drop_count <= drop_count + 32'd1;
        overflow <= 1'b1;
      end
    end
  end

  // NOTE: the beat storage has no reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_ptr] <= beat_next;
      mem_last[wr_ptr] <= push_tlast;
    end
  end

  assign M_AXIS_tvalid = (count != '0);
  assign M_AXIS_tdata  = M_AXIS_tvalid ? mem_data[rd_ptr] : '0;
  assign M_AXIS_tlast  = M_AXIS_tvalid & mem_last[rd_ptr];
  assign fifo_level    = count;

endmodule

// File: tb/tb_cms_trace_packer.sv
// Directed bench for cms_trace_packer: table-driven record packing plus hand-written
// sequences for saturation, overflow, flush and mid-stream reset.
module tb_cms_trace_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  instr = '0;
  logic [63:0]  pc = '0;
  logic         pc_valid = 1'b0;
  logic [2:0]   performance_events = '0;
  logic         en = 1'b1;
  logic [7:0]   ctrl_addr = '0;
  logic [63:0]  ctrl_wdata = '0;
  logic         ctrl_write_enable = 1'b0;
  logic [31:0]  tlast_interval = 32'd2;
  logic         M_AXIS_tvalid;
  logic         M_AXIS_tready = 1'b0;
  logic [511:0] M_AXIS_tdata;
  logic         M_AXIS_tlast;
  logic [3:0]   fifo_level;
  logic [31:0]  drop_count;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  cms_trace_packer dut (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc), .pc_valid(pc_valid),
    .performance_events(performance_events), .en(en), .ctrl_addr(ctrl_addr),
    .ctrl_wdata(ctrl_wdata), .ctrl_write_enable(ctrl_write_enable),
    .tlast_interval(tlast_interval), .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tready(M_AXIS_tready), .M_AXIS_tdata(M_AXIS_tdata),
    .M_AXIS_tlast(M_AXIS_tlast), .fifo_level(fifo_level),
    .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0] pre_ev;
    int         pre_n;
    logic [2:0] cap_ev;
    logic [6:0] e0, e1, e2;
  } rec_vec_t;

  rec_vec_t vecs [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl_write(input logic [7:0] addr, input logic [63:0] data);
    ctrl_addr = addr;
    ctrl_wdata = data;
    ctrl_write_enable = 1'b1;
    tick();
    ctrl_write_enable = 1'b0;
    tick();
  endtask

  task automatic capture(input logic [63:0] p, input logic [2:0] ev);
    pc = p;
    instr = 32'h13;
    pc_valid = 1'b1;
    performance_events = ev;
    tick();
    pc_valid = 1'b0;
    performance_events = '0;
  endtask

  task automatic reset_run();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ctrl_write(8'h00, 64'd1);
  endtask

  function automatic logic [127:0] slot_of(input logic [511:0] d, input int k);
    return d[k*128 +: 128];
  endfunction

  task automatic check_slot(input string name, input int k, input logic [63:0] epc,
                            input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
    logic [127:0] r;
    r = slot_of(M_AXIS_tdata, k);
    check({name, " instr"}, 128'(r[31:0]), 128'h13);
    check({name, " pc"},    128'(r[95:32]), 128'(epc));
    check({name, " c0"},    128'(r[102:96]), 128'(e0));
    check({name, " c1"},    128'(r[109:103]), 128'(e1));
    check({name, " c2"},    128'(r[116:110]), 128'(e2));
    check({name, " pad"},   128'(r[127:117]), 128'h0);
  endtask

  initial begin
    // Reset state
    tick();
    check("reset tvalid", 128'(M_AXIS_tvalid), 128'h0);
    check("reset tdata lo", M_AXIS_tdata[127:0], 128'h0);
    check("reset level", 128'(fifo_level), 128'h0);
    check("reset drops", 128'(drop_count), 128'h0);
    check("reset overflow", 128'(overflow), 128'h0);
    rst = 1'b0;
    tick();

    // Table-driven: four records with differing event histories form one beat
    vecs[0] = '{pre_ev: 3'b000, pre_n: 0, cap_ev: 3'b001, e0: 7'd1, e1: 7'd0, e2: 7'd0};
    vecs[1] = '{pre_ev: 3'b010, pre_n: 3, cap_ev: 3'b010, e0: 7'd0, e1: 7'd4, e2: 7'd0};
    vecs[2] = '{pre_ev: 3'b100, pre_n: 5, cap_ev: 3'b000, e0: 7'd0, e1: 7'd0, e2: 7'd5};
    vecs[3] = '{pre_ev: 3'b111, pre_n: 2, cap_ev: 3'b111, e0: 7'd3, e1: 7'd3, e2: 7'd3};
    tlast_interval = 32'd2;
    ctrl_write(8'h00, 64'd1);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < vecs[k].pre_n; j++) begin
        performance_events = vecs[k].pre_ev;
        tick();
      end
      performance_events = '0;
      if (k == 3) check("tvalid before last capture", 128'(M_AXIS_tvalid), 128'h0);
      capture(64'h1000 + 64'(4*k), vecs[k].cap_ev);
    end
    check("tvalid after 4th capture", 128'(M_AXIS_tvalid), 128'h1);
    check("tlast beat0", 128'(M_AXIS_tlast), 128'h0);
    check("level one beat", 128'(fifo_level), 128'h1);
    for (int k = 0; k < 4; k++)
      check_slot($sformatf("vec slot%0d", k), k, 64'h1000 + 64'(4*k),
                 vecs[k].e0, vecs[k].e1, vecs[k].e2);
    M_AXIS_tready = 1'b1;
    tick();
    check("pop empties fifo", 128'(fifo_level), 128'h0);
    M_AXIS_tready = 1'b0;

    // Two beats with tlast_interval=2: tlast on the second only
    reset_run();
    M_AXIS_tready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      capture(64'h2000 + 64'(4*j), 3'b000);
      if (j == 3) begin
        check("pkt beat1 tvalid", 128'(M_AXIS_tvalid), 128'h1);
        check("pkt beat1 tlast", 128'(M_AXIS_tlast), 128'h0);
      end
      if (j == 7) begin
        check("pkt beat2 tvalid", 128'(M_AXIS_tvalid), 128'h1);
        check("pkt beat2 tlast", 128'(M_AXIS_tlast), 128'h1);
      end
    end
    tick();
    check("pkt level drained", 128'(fifo_level), 128'h0);
    M_AXIS_tready = 1'b0;

    // Counter saturation
    reset_run();
    performance_events = 3'b001;
    for (int j = 0; j < 200; j++) tick();
    performance_events = '0;
    for (int j = 0; j < 4; j++) capture(64'h3000 + 64'(4*j), 3'b000);
    check("sat tvalid", 128'(M_AXIS_tvalid), 128'h1);
    check("sat slot0 c0", 128'(M_AXIS_tdata[102:96]), 128'd127);
    check("sat slot1 c0", 128'(M_AXIS_tdata[128+96 +: 7]), 128'd0);

    // Overflow, drop accounting and clear-vs-drop coincidence
    reset_run();
    for (int j = 0; j < 36; j++) capture(64'h4000 + 64'(4*j), 3'b000);
    check("ovf level", 128'(fifo_level), 128'd8);
    check("ovf drops", 128'(drop_count), 128'd1);
    check("ovf sticky", 128'(overflow), 128'h1);
    check("ovf head pc", 128'(M_AXIS_tdata[95:32]), 128'h4000);
    ctrl_write(8'h02, 64'd0);
    check("clear drops", 128'(drop_count), 128'd0);
    check("clear overflow", 128'(overflow), 128'h0);
    check("clear keeps level", 128'(fifo_level), 128'd8);
    for (int j = 0; j < 3; j++) capture(64'h5000 + 64'(4*j), 3'b000);
    pc = 64'h500C;
    pc_valid = 1'b1;
    ctrl_addr = 8'h02;
    ctrl_write_enable = 1'b1;
    tick();
    pc_valid = 1'b0;
    ctrl_write_enable = 1'b0;
    tick();
    check("clear+drop count", 128'(drop_count), 128'd1);
    check("clear+drop sticky", 128'(overflow), 128'h1);
    M_AXIS_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d tvalid", i), 128'(M_AXIS_tvalid), 128'h1);
      check($sformatf("drain%0d tlast", i), 128'(M_AXIS_tlast), 128'(i % 2 == 1));
      tick();
    end
    check("drain empty", 128'(fifo_level), 128'h0);
    M_AXIS_tready = 1'b0;

    // Flush of a partial beat, then a no-op flush
    reset_run();
    capture(64'h6000, 3'b000);
    capture(64'h6004, 3'b000);
    check("partial not pushed", 128'(M_AXIS_tvalid), 128'h0);
    ctrl_addr = 8'h01;
    ctrl_write_enable = 1'b1;
    tick();
    ctrl_write_enable = 1'b0;
    check("flush tvalid", 128'(M_AXIS_tvalid), 128'h1);
    check("flush tlast", 128'(M_AXIS_tlast), 128'h1);
    check("flush slot1 pc", 128'(M_AXIS_tdata[128+32 +: 64]), 128'h6004);
    check("flush slot2 zero", M_AXIS_tdata[383:256], 128'h0);
    check("flush slot3 zero", M_AXIS_tdata[511:384], 128'h0);
    tick();
    M_AXIS_tready = 1'b1;
    tick();
    M_AXIS_tready = 1'b0;
    ctrl_write(8'h01, 64'd0);
    check("empty flush no beat", 128'(fifo_level), 128'h0);

    // Flush coinciding with beat completion forces tlast
    reset_run();
    tlast_interval = 32'd5;
    for (int j = 0; j < 3; j++) capture(64'h7000 + 64'(4*j), 3'b000);
    pc = 64'h700C;
    pc_valid = 1'b1;
    ctrl_addr = 8'h01;
    ctrl_write_enable = 1'b1;
    tick();
    pc_valid = 1'b0;
    ctrl_write_enable = 1'b0;
    check("flush+full level", 128'(fifo_level), 128'h1);
    check("flush+full tlast", 128'(M_AXIS_tlast), 128'h1);
    check("flush+full slot3 pc", 128'(M_AXIS_tdata[384+32 +: 64]), 128'h700C);
    tick();
    tlast_interval = 32'd2;

    // Asynchronous reset with buffered beats; run bit must be rewritten
    reset_run();
    for (int j = 0; j < 12; j++) capture(64'h8000 + 64'(4*j), 3'b000);
    check("pre-reset level", 128'(fifo_level), 128'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async rst tvalid", 128'(M_AXIS_tvalid), 128'h0);
    check("async rst level", 128'(fifo_level), 128'h0);
    tick();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) capture(64'h9000 + 64'(4*j), 3'b000);
    tick();
    check("no capture while run=0", 128'(M_AXIS_tvalid), 128'h0);
    ctrl_write(8'h00, 64'd1);
    for (int j = 0; j < 4; j++) capture(64'h9000 + 64'(4*j), 3'b000);
    check("capture after run", 128'(M_AXIS_tvalid), 128'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cms_trace_packer.md
Name: cms_trace_packer

Overview:
Parametrised successor of the continuous monitoring system's data-packet path. Captures one trace record per valid executed instruction (instr, pc, per-event counters accumulated since the previous record) and packs RECORDS_PER_BEAT records into each AXI-Stream beat. Beats are buffered in an internal FIFO and streamed to the DMA FIFO, with tlast asserted on a programmable interval. Sits between the processor trace taps and the AXI-Stream DMA.

Parameters:
XLEN, 64, pc width
INSTR_WIDTH, 32, instruction width
NUM_COUNTERS, 3, number of tracked performance events/counters
COUNTER_WIDTH, 7, width of each per-record event counter
RECORD_WIDTH, 128, padded record width; must be >= INSTR_WIDTH+XLEN+NUM_COUNTERS*COUNTER_WIDTH
AXI_DATA_WIDTH, 512, stream width; must be an integer multiple of RECORD_WIDTH; RECORDS_PER_BEAT = AXI_DATA_WIDTH/RECORD_WIDTH (localparam, 4 by default)
FIFO_DEPTH, 8, beat FIFO depth, power of two >= 2
CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED, 1, 1 = ctrl write acts on rising edge of ctrl_write_enable; 0 = acts every cycle it is high

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
instr  in  INSTR_WIDTH  executed instruction
pc  in  XLEN  its pc
pc_valid  in  1  instr/pc executed this cycle
performance_events  in  NUM_COUNTERS  one-cycle event pulses
en  in  1  external enable (gated with run bit)
ctrl_addr  in  8  control address
ctrl_wdata  in  64  control data
ctrl_write_enable  in  1  control write strobe
tlast_interval  in  32  beats per packet
M_AXIS_tvalid  out  1  stream valid
M_AXIS_tready  in  1  stream ready
M_AXIS_tdata  out  AXI_DATA_WIDTH  packed records, slot 0 in LSBs
M_AXIS_tlast  out  1  end of packet
fifo_level  out  log2(FIFO_DEPTH)+1  beats currently buffered
drop_count  out  32  beats dropped due to full FIFO
overflow  out  1  sticky: at least one beat dropped

Behaviour:
- Reset (async, active-high): all outputs 0; run bit 0; counters, slot index, beat counter, FIFO pointers, drop_count, overflow cleared.
- Record layout, LSB first: instr, pc, counter[0]..counter[NUM_COUNTERS-1], zero padding.
- Capture: when en & run & pc_valid. Record counter field i = saturate(counter[i] + performance_events[i]) at 2^COUNTER_WIDTH-1; counter[i] then clears to 0. Non-capture cycles: counter[i] saturating-increments on event[i]. Counters run only while en & run.
- Packing: record written to slot index s, s increments. When s reaches RECORDS_PER_BEAT-1 and is captured, the beat is pushed to the FIFO in that same cycle; s returns to 0.
- Latency: beat completed on cycle N -> M_AXIS_tvalid high on N+1 if FIFO was empty (first-word fall-through, registered).
- tlast: beat counter b counts pushed beats; pushed beat carries tlast=1 when b == max(tlast_interval,1)-1, then b=0. tlast is stored with the beat in the FIFO.
- Handshake: transfer when tvalid & tready; tdata/tlast stable while tvalid & !tready.
- FIFO full on push: beat discarded, drop_count += 1 (saturating), overflow=1, b not advanced. Push and pop in the same cycle while full: pop first, push accepted.
- Ctrl writes (one action per qualified strobe):
  0x00: run = wdata[0]. Clearing run leaves a partial beat in place.
  0x01: flush. If s>0, push the partial beat, unused slots zero, tlast=1, b=0, s=0. If s==0, no-op. Flush coinciding with a capture includes that record. Flush coinciding with beat completion: the complete beat gets tlast=1.
  0x02: drop_count=0, overflow=0. Coinciding with a drop, the clear wins, then the new drop counts: drop_count=1, overflow=1.
  Other addresses: ignored.
- tlast_interval change mid-packet: compared against the current b; if b already exceeds the new value, tlast is asserted on the next push.

Test Plan:
- Reset, run=1, en=1, 4 consecutive pc_valid (pc 0x1000..0x100C, instr 0x13) -> one beat, tvalid 1 cycle after the 4th capture, slot k pc=0x1000+4k, tlast=0 (tlast_interval=2).
- 8 captures, tlast_interval=2, tready=1 -> 2 beats, tlast on the second only; fifo_level returns to 0.
- 200 branch event pulses, then a capture -> counter[0] field=127 (saturated); next record field=0.
- tready=0, 9 beats generated (FIFO_DEPTH=8) -> fifo_level=8, drop_count=1, overflow=1; ctrl write 0x02 -> both 0.
- 2 captures, then ctrl write 0x01 -> beat with slots 2..3 zero, tlast=1; second flush with s=0 -> no beat.
- Assert rst while tvalid=1 and the FIFO holds 3 beats -> tvalid=0 and fifo_level=0 immediately; run=0, so no capture until 0x00 is rewritten.
